// File: rtl/uart_csr_pkg.sv
// Shared definitions for the UART CSR controller.
// Register map, status bit indices and FSM state type.
package uart_csr_pkg;

  localparam logic [2:0] UART_ADDR_RXDATA = 3'd0;
  localparam logic [2:0] UART_ADDR_TXDATA = 3'd1;
  localparam logic [2:0] UART_ADDR_STATUS = 3'd2;

  localparam int STAT_RRDY = 7;
  localparam int STAT_TRDY = 6;
  localparam int STAT_FE   = 1;
  localparam int STAT_PE   = 0;

  typedef enum logic [2:0] {
    IDLE,
    RD_STAT,
    WT_STAT,
    RD_RX,
    WT_RX,
    WR_TX
  } uart_ctrl_state_t;

endpackage

// File: rtl/uart_csr_ctrl_if.sv
// Byte streams plus Avalon-MM CSR bus of the UART controller.
// master: the controller side; slave: the UART / stream user side.
interface uart_csr_ctrl_if;

  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic [2:0]  uart_csr_address;
  logic        uart_csr_begintransfer;
  logic        uart_csr_chipselect;
  logic        uart_csr_read_n;
  logic        uart_csr_write_n;
  logic [15:0] uart_csr_writedata;
  logic [15:0] uart_csr_readdata;

  modport master (
    input  tx_data, tx_valid, uart_csr_readdata,
    output tx_ready, rx_data, rx_valid, rx_err,
    output uart_csr_address, uart_csr_begintransfer,
    output uart_csr_chipselect, uart_csr_read_n,
    output uart_csr_write_n, uart_csr_writedata
  );

  modport slave (
    output tx_data, tx_valid, uart_csr_readdata,
    input  tx_ready, rx_data, rx_valid, rx_err,
    input  uart_csr_address, uart_csr_begintransfer,
    input  uart_csr_chipselect, uart_csr_read_n,
    input  uart_csr_write_n, uart_csr_writedata
  );

endinterface

// File: rtl/uart_csr_ctrl_fifo.sv
// csr_byte_fifo: 8-bit synchronous FIFO for queued TX bytes.
// Ports: push/push_data in, pop in, head/empty/full out.
module csr_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];

  // Extra MSB on each pointer tells full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_csr_ctrl.sv
// Avalon-MM master owning the UART CSR port: polls status,
// streams RX bytes out, drains the TX FIFO into txdata.
// Ports: clk_clk, reset_reset (async high), bus (master modport).
module uart_csr_ctrl
  import uart_csr_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int READ_LATENCY = 1,
  parameter int POLL_CYCLES  = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  uart_csr_ctrl_if.master bus
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [PW-1:0] POLL_ONE  = PW'(1);
  localparam logic [1:0]    LAT_LAST  = 2'(READ_LATENCY - 1);

  uart_ctrl_state_t state;
  logic [PW-1:0]    poll_cnt;
  logic [1:0]       lat_cnt;
  logic             err_q;
  logic             rx_pend;

  logic [7:0]  rx_data_q;
  logic        rx_err_q;
  logic        rx_valid_q;
  logic [2:0]  addr_q;
  logic        bt_q;
  logic        cs_q;
  logic        rd_n_q;
  logic        wr_n_q;
  logic [15:0] wdata_q;

  logic [7:0]  head;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [15:0] rdata;
  logic        unused_rd;

  assign rdata     = bus.uart_csr_readdata;
  assign unused_rd = ^rdata[15:8];
  assign push      = bus.tx_valid && !full;
  assign pop       = (state == WR_TX);

  csr_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .push        (push),
    .push_data   (bus.tx_data),
    .pop         (pop),
    .head        (head),
    .empty       (empty),
    .full        (full)
  );

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state      <= IDLE;
      poll_cnt   <= '0;
      lat_cnt    <= '0;
      err_q      <= 1'b0;
      rx_pend    <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_err_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      addr_q     <= 3'd0;
      bt_q       <= 1'b0;
      cs_q       <= 1'b0;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      wdata_q    <= 16'h0000;
    end else begin
      // Bus is idle unless a transition below issues a command.
      addr_q     <= 3'd0;
      bt_q       <= 1'b0;
      cs_q       <= 1'b0;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      wdata_q    <= 16'h0000;
      // rx_valid trails the data capture by one cycle.
      rx_pend    <= 1'b0;
      rx_valid_q <= rx_pend;
      unique case (state)
        IDLE: begin
          if (!empty || poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
            state    <= RD_STAT;
            addr_q   <= UART_ADDR_STATUS;
            bt_q     <= 1'b1;
            cs_q     <= 1'b1;
            rd_n_q   <= 1'b0;
          end else begin
            poll_cnt <= poll_cnt + POLL_ONE;
          end
        end
        RD_STAT: begin
          lat_cnt <= 2'd0;
          state   <= WT_STAT;
        end
        WT_STAT: begin
          if (lat_cnt == LAT_LAST) begin
            err_q <= rdata[STAT_PE] | rdata[STAT_FE];
            if (rdata[STAT_RRDY]) begin
              state  <= RD_RX;
              addr_q <= UART_ADDR_RXDATA;
              bt_q   <= 1'b1;
              cs_q   <= 1'b1;
              rd_n_q <= 1'b0;
            end else if (rdata[STAT_TRDY] && !empty) begin
              state   <= WR_TX;
              addr_q  <= UART_ADDR_TXDATA;
              bt_q    <= 1'b1;
              cs_q    <= 1'b1;
              wr_n_q  <= 1'b0;
              wdata_q <= {8'h00, head};
            end else begin
              state <= IDLE;
            end
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        RD_RX: begin
          lat_cnt <= 2'd0;
          state   <= WT_RX;
        end
        WT_RX: begin
          if (lat_cnt == LAT_LAST) begin
            rx_data_q <= rdata[7:0];
            rx_err_q  <= err_q;
            rx_pend   <= 1'b1;
            state     <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        WR_TX: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready               = !full;
  assign bus.rx_data                = rx_data_q;
  assign bus.rx_err                 = rx_err_q;
  assign bus.rx_valid               = rx_valid_q;
  assign bus.uart_csr_address       = addr_q;
  assign bus.uart_csr_begintransfer = bt_q;
  assign bus.uart_csr_chipselect    = cs_q;
  assign bus.uart_csr_read_n        = rd_n_q;
  assign bus.uart_csr_write_n       = wr_n_q;
  assign bus.uart_csr_writedata     = wdata_q;

endmodule

// File: doc/uart_csr_ctrl.md
# uart_csr_ctrl

Avalon-MM master that drives the UART core's `uart_csr` slave port so the rest of the design never has to poll UART registers. Bytes are pushed into an internal TX FIFO over a valid/ready stream. The FSM polls the UART status register, reads received bytes out as a pulse stream, and writes queued bytes to `txdata` whenever the transmitter is ready. It sits beside the UART instance and owns its CSR port exclusively.

## Interface
Parameters:
- `DEPTH`, 8: TX FIFO depth in bytes; power of two, 2..64.
- `READ_LATENCY`, 1: cycles from the read-command cycle to valid `uart_csr_readdata`; 1..3.
- `POLL_CYCLES`, 16: idle cycles between status polls while the TX FIFO is empty; ≥ 2.

Ports (one clock `clk_clk`; reset `reset_reset` is asynchronous and active-high):
- `clk_clk`  in  1  system clock.
- `reset_reset`  in  1  async active-high reset.
- `tx_data`  in  8  byte to transmit.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO not full; a push happens when `tx_valid && tx_ready`.
- `rx_data`  out  8  received byte.
- `rx_valid`  out  1  one-cycle pulse; `rx_data`/`rx_err` are valid. No backpressure.
- `rx_err`  out  1  parity or framing error flagged for this byte.
- `uart_csr_address`  out  3  register address.
- `uart_csr_begintransfer`  out  1  first (only) cycle of an access.
- `uart_csr_chipselect`  out  1  access active.
- `uart_csr_read_n`  out  1  active-low read.
- `uart_csr_write_n`  out  1  active-low write.
- `uart_csr_writedata`  out  16  write data.
- `uart_csr_readdata`  in  16  read data.

## Operation
- UART register map: 0 rxdata, 1 txdata, 2 status. Status bits: RRDY = 7, TRDY = 6, FE = 1, PE = 0.
- States: IDLE, RD_STAT, WT_STAT, RD_RX, WT_RX, WR_TX.
- IDLE → RD_STAT when the FIFO is non-empty, or when the poll counter reaches POLL_CYCLES−1. The poll counter clears on leaving IDLE and counts only in IDLE.
- RD_STAT: one cycle with address=2, chipselect=1, begintransfer=1, read_n=0. Then go to WT_STAT.
- WT_STAT: wait READ_LATENCY cycles and sample status on the last cycle. Then branch:
  - RRDY=1 → RD_RX. RX has priority over TX.
  - else TRDY=1 and FIFO non-empty → WR_TX.
  - else → IDLE.
- Latch `err_q` = PE|FE from the sampled status.
- RD_RX: one cycle with address=0 and read strobes, then WT_RX.
- WT_RX: wait READ_LATENCY cycles. On the last cycle register `rx_data` = readdata[7:0] and `rx_err` = `err_q`, and pulse `rx_valid` on the next cycle. Go to IDLE.
- WR_TX: one cycle with address=1, chipselect=1, begintransfer=1, write_n=0, writedata = {8'h00, FIFO head}. Pop the FIFO in the same cycle, then go to IDLE.
- Outside access cycles: chipselect=0, begintransfer=0, read_n=1, write_n=1, address=0, writedata=0.
- FIFO pointers are log2(DEPTH)+1 bits wide, with wrap-around on the MSB. Full = MSBs differ and LSBs are equal.
  - `tx_ready` = !full, taken from registered pointers.
  - A push and a pop in the same cycle are both honoured.
  - When full, a pop does not make `tx_ready` high in that same cycle.
- Reset mid-access aborts immediately: FSM goes to IDLE, FIFO empties, and the queued bytes are lost.

## Timing
- Reset values:
  - `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `rx_err`=0.
  - `uart_csr_read_n`=1, `uart_csr_write_n`=1, chipselect=0, begintransfer=0, address=0, writedata=0.
- All CSR outputs are registered. Each access is exactly one command cycle; the slave uses no waitrequest.
- TX, FIFO non-empty, UART ready: push cycle t → RD_STAT t+2 (FIFO count visible t+1, IDLE at t+1) → WR_TX at t+3+READ_LATENCY.
- Back-to-back TX sustains one byte per 3+READ_LATENCY cycles while TRDY stays high.
- RX: RD_STAT at cycle s → `rx_valid` at s+3+2·READ_LATENCY.
- When the FIFO is empty, the interval between status reads is POLL_CYCLES+1+READ_LATENCY cycles.

## Structure
- Package `uart_csr_pkg` holds:
  - address constants `UART_ADDR_RXDATA`/`TXDATA`/`STATUS`;
  - status bit indices RRDY/TRDY/FE/PE;
  - the `uart_ctrl_state_t` enum.
- Sub-module `csr_byte_fifo` (parameter DEPTH): synchronous 8-bit FIFO with push, pop, head, empty and full. Same clock and reset as the parent.
- The top FSM, poll counter and latency counter live in `uart_csr_ctrl`.

## Test plan
- Reset: assert `reset_reset` with `tx_valid`=1 → all outputs at reset values, no CSR access. After release, the first status read occurs after POLL_CYCLES IDLE cycles.
- Single TX: slave returns status 16'h0040. Push 8'hA5 → exactly one write with address 1 and writedata 16'h00A5. No further write; `tx_ready` stays 1.
- RX priority: FIFO holds 8'h11 and status returns 16'h00C0 then readdata 16'h005A → rxdata is read first. `rx_valid` pulses one cycle with `rx_data`=8'h5A and `rx_err`=0. The TX write follows on the next poll.
- Backpressure/full, DEPTH=8: status TRDY=0 and 9 pushes attempted → 8 accepted, `tx_ready`=0. Set TRDY=1 → 8 writes carry bytes in push order, and `tx_ready` rises after the first pop.
- Error and latency, READ_LATENCY=3: status 16'h0082, rxdata 16'h0033 → `rx_err`=1, `rx_data`=8'h33, with `rx_valid` exactly 9 cycles after the RD_STAT cycle.
- Reset mid-operation: assert reset during WT_STAT with 3 bytes queued → FSM returns to IDLE and the FIFO empties. No write is issued after release until a new push.
